// File: rtl/dm_bus_arbiter.sv
// Data-memory port arbiter: CPU M-stage has priority, one secondary master gets idle-cycle beats.
// Optional starvation guard (forced secondary grant with CPU stall) enabled by ARB_STARVE_GUARD_EN.
module dm_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        sec_req,
    input  logic [31:0] sec_addr,
    input  logic [31:0] sec_wdata,
    input  logic [3:0]  sec_byteen,
    output logic        sec_gnt,
    output logic        sec_rvalid,
    output logic [31:0] sec_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata
);

    logic        force_gnt;
    logic        sel_sec;
    logic        sec_load;
    logic        rvalid_p1;
    logic [31:0] rdata_p1;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    assign force_gnt = (starve_cnt == LIMIT);

    // Counts consecutive denied cycles; any grant or withdrawn request restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!sec_req || sel_sec) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign force_gnt = 1'b0;
`endif

    assign sel_sec   = sec_req && (!cpu_req || force_gnt);
    assign sec_gnt   = sel_sec;
    assign cpu_stall = cpu_req && sel_sec;
    assign cpu_rdata = mem_rdata;
    assign sec_load  = sel_sec && (sec_byteen == 4'd0);

    always_comb begin
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_byteen = cpu_req ? cpu_byteen : 4'd0;
        if (sel_sec) begin
            mem_addr   = sec_addr;
            mem_wdata  = sec_wdata;
            mem_byteen = sec_byteen;
        end
    end

    // Stage p1: registered read return for the secondary master.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_p1 <= 1'b0;
            rdata_p1  <= 32'd0;
        end else begin
            rvalid_p1 <= sec_load;
            if (sec_load) begin
                rdata_p1 <= mem_rdata;
            end
        end
    end

    assign sec_rvalid = rvalid_p1;
    assign sec_rdata  = rdata_p1;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed self-checking bench for dm_bus_arbiter with a small word memory model.
// Expectations adapt to whether ARB_STARVE_GUARD_EN is defined (STARVE_LIMIT = 3).
module tb_dm_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        sec_req;
    logic [31:0] sec_addr;
    logic [31:0] sec_wdata;
    logic [3:0]  sec_byteen;
    logic        sec_gnt;
    logic        sec_rvalid;
    logic [31:0] sec_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int          wr_count = 0;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    dm_bus_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteen(cpu_byteen), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .sec_req(sec_req), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_byteen(sec_byteen), .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid),
        .sec_rdata(sec_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_byteen != 4'd0) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          wr_snap;
        logic        exp_gnt;
        logic [31:0] stall_val;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[64] = 32'hDEADBEEF;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_byteen = 4'd0;
        sec_req = 1'b0; sec_addr = 32'd0; sec_wdata = 32'd0; sec_byteen = 4'd0;
        @(posedge clk);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("reset_rvalid", 32'(sec_rvalid), 32'd0);
        chk("reset_rdata", sec_rdata, 32'd0);

        // Idle secondary load
        next_cycle();
        sec_req = 1'b1; sec_addr = 32'h100; sec_byteen = 4'd0;
        #1;
        chk("idle_gnt", 32'(sec_gnt), 32'd1);
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_mem_addr", mem_addr, 32'h100);
        chk("idle_mem_byteen", 32'(mem_byteen), 32'd0);
        next_cycle();
        sec_req = 1'b0;
        #1;
        chk("idle_rvalid", 32'(sec_rvalid), 32'd1);
        chk("idle_rdata", sec_rdata, 32'hDEADBEEF);
        chk("idle_gnt_off", 32'(sec_gnt), 32'd0);
        chk("idle_stall2", 32'(cpu_stall), 32'd0);
        next_cycle();
        chk("idle_rvalid_drop", 32'(sec_rvalid), 32'd0);
        chk("idle_rdata_hold", sec_rdata, 32'hDEADBEEF);

        // CPU priority store alongside a secondary store
        cpu_req = 1'b1; cpu_addr = 32'h20; cpu_byteen = 4'hF; cpu_wdata = 32'h12345678;
        sec_req = 1'b1; sec_addr = 32'h40; sec_byteen = 4'hF; sec_wdata = 32'hAAAA5555;
        #1;
        chk("prio_mem_addr", mem_addr, 32'h20);
        chk("prio_mem_wdata", mem_wdata, 32'h12345678);
        chk("prio_mem_byteen", 32'(mem_byteen), 32'hF);
        chk("prio_gnt", 32'(sec_gnt), 32'd0);
        chk("prio_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        #1;
        chk("sec_wr_gnt", 32'(sec_gnt), 32'd1);
        chk("sec_wr_addr", mem_addr, 32'h40);
        chk("sec_wr_byteen", 32'(mem_byteen), 32'hF);
        next_cycle();
        sec_req = 1'b0;
        #1;
        chk("no_spurious_byteen", 32'(mem_byteen), 32'd0);
        cpu_req = 1'b1; cpu_byteen = 4'd0; cpu_addr = 32'h20;
        #1;
        chk("cpu_rd_0x20", cpu_rdata, 32'h12345678);
        cpu_addr = 32'h40;
        #1;
        chk("cpu_rd_0x40", cpu_rdata, 32'hAAAA5555);
        next_cycle();

        // Contention: CPU load and secondary load held together
        cpu_addr = 32'h20; sec_req = 1'b1; sec_addr = 32'h100; sec_byteen = 4'd0;
`ifdef ARB_STARVE_GUARD_EN
        for (int c = 0; c < 9; c++) begin
            exp_gnt = (c == 3) || (c == 7);
            #1;
            chk($sformatf("starve_gnt_c%0d", c), 32'(sec_gnt), 32'(exp_gnt));
            chk($sformatf("starve_stall_c%0d", c), 32'(cpu_stall), 32'(exp_gnt));
            chk($sformatf("starve_addr_c%0d", c), mem_addr, exp_gnt ? 32'h100 : 32'h20);
            if (c == 4 || c == 8) begin
                chk($sformatf("starve_rvalid_c%0d", c), 32'(sec_rvalid), 32'd1);
                chk($sformatf("starve_rdata_c%0d", c), sec_rdata, 32'hDEADBEEF);
            end
            next_cycle();
        end
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            chk($sformatf("nog_gnt_c%0d", c), 32'(sec_gnt), 32'd0);
            chk($sformatf("nog_stall_c%0d", c), 32'(cpu_stall), 32'd0);
            next_cycle();
        end
`endif
        cpu_req = 1'b0;
        #1;
        chk("cpu_drop_gnt", 32'(sec_gnt), 32'd1);
        stall_val = 32'(cpu_stall);
        chk("cpu_drop_stall", stall_val, 32'd0);
        next_cycle();
        sec_req = 1'b0;
        next_cycle();

        // Reset during a secondary read return
        sec_req = 1'b1; sec_addr = 32'h40; sec_byteen = 4'd0;
        wr_snap = wr_count;
        #1;
        chk("rst_mid_gnt", 32'(sec_gnt), 32'd1);
        reset = 1'b1;
        next_cycle();
        sec_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(sec_rvalid), 32'd0);
        chk("rst_mid_rdata", sec_rdata, 32'd0);
        chk("rst_mid_no_write", 32'(wr_count - wr_snap), 32'd0);
        chk("rst_mid_mem_intact", mem[16], 32'hAAAA5555);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
